tiny_dnn_layer_seq: RTL and testbench
=====================================

# tiny_dnn_layer_seq

Layer-level sequencer in front of the convolution execution controller. It accepts one layer command from the host, then streams weight and bias words into the kernel buffers. It starts the execution controller with an `s_init` pulse, waits for `s_fin`, and lets the output path drain before signalling completion. One command is in flight at a time.

## Interface
Parameters:
- `WA_W`, 10, weight buffer address width
- `BA_W`, 4, bias buffer address width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`
- `cmd_backprop`  in  1  layer runs in backprop mode
- `cmd_skip_load`  in  1  buffers already loaded; go straight to execution
- `cmd_wlast`  in  WA_W  index of last weight word (word count minus 1)
- `cmd_blast`  in  BA_W  index of last bias word
- `abort`  in  1  synchronous abort of the current command
- `src_valid`  in  1  host data word present
- `src_ready`  out  1  data word consumed when `src_valid & src_ready`
- `wwrite`  out  1  weight buffer write strobe
- `bwrite`  out  1  bias buffer write strobe
- `waddr`  out  WA_W  weight write address
- `baddr`  out  BA_W  bias write address
- `backprop`  out  1  latched mode to the execution controller
- `run`  out  1  execution phase active
- `s_init`  out  1  one-cycle start pulse to the execution controller
- `s_fin`  in  1  execution controller finished
- `out_busy`  in  1  output path still holds data
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
States: IDLE, WLOAD, BLOAD, INIT, RUN, DRAIN, DONE.

- **IDLE**
  - `cmd_ready`=1.
  - On handshake: latch `backprop`, `cmd_wlast`, `cmd_blast`, and clear the load counter.
  - Next state is INIT if `cmd_skip_load`, else WLOAD.
- **WLOAD**
  - `src_ready`=1.
  - `wwrite` = `src_valid`.
  - `waddr` = counter; the counter increments on each accepted word.
  - On the accepted word with counter == wlast:
    - counter clears;
    - next state is INIT if latched `backprop` (backprop has no bias);
    - otherwise next state is BLOAD.
- **BLOAD**
  - Same as WLOAD, using `bwrite`/`baddr` and blast.
  - On the last word, next state is INIT.
- **INIT**: `s_init`=1 and `run`=1 for exactly one cycle; next state is RUN.
- **RUN**: `run`=1; on `s_fin`, next state is DRAIN.
- **DRAIN**: `run`=0; when `out_busy`=0, next state is DONE.
- **DONE**: `done`=1 for one cycle; next state is IDLE.
- **Abort**: `abort` in any non-IDLE state forces IDLE next cycle.
  - Write strobes drop the same cycle (gated combinationally by `!abort`).
  - No `done` pulse.
  - `abort` in IDLE has no effect.
- **Ignored events**
  - `s_fin` outside RUN.
  - `src_valid` outside WLOAD/BLOAD (`src_ready`=0, no strobe).
  - `cmd_valid` while `busy`.
- **Widths**: the counter is max(WA_W,BA_W) bits. `baddr` takes the low BA_W bits. wlast=0 or blast=0 loads exactly one word.

## Timing
- **Reset values**: state IDLE, all outputs 0 except `cmd_ready`=1; `waddr`/`baddr`/`backprop` = 0.
- **Reset mid-operation**: returns to IDLE immediately (asynchronous); strobes drop without a clock.
- **Strobe timing**: `wwrite`/`bwrite`/`src_ready` are combinational from state and `src_valid`. `waddr`/`baddr` are registered and stable during the strobe cycle.
- **Command to start latency**:
  - handshake at cycle 0 with skip: `s_init` in cycle 1;
  - with load: first `wwrite` no earlier than cycle 1.
- **Load to start latency**: the last load word at cycle N gives `s_init` at N+1.
- **`s_fin` at cycle M**: DRAIN at M+1.
  - If `out_busy`=0 at M+1, `done` at M+2 and `cmd_ready` at M+3.
- **Back-to-back**: a new command is accepted the cycle after `done`.

## Structure
- Package `tiny_dnn_pkg`: state enum `seq_state_t` and width constants WA_W/BA_W defaults.
- One natural sub-module, `tiny_dnn_ld_cnt`: a load counter with clear, increment enable, and last-compare output `cnt_last`. It is instantiated once and shared by WLOAD/BLOAD.
- Flops use the existing `dff` primitive where practical.

## Test plan
- **Forward load**: wlast=3, blast=1, `src_valid` held 1.
  - `wwrite` on 4 cycles with `waddr` 0..3, then `bwrite` on 2 cycles with `baddr` 0..1.
  - `s_init` next cycle; `s_fin` returned; `done` 2 cycles later.
- **Backprop**: wlast=2 with backprop=1.
  - 3 weight writes, no `bwrite`, `s_init` the cycle after the third write, `backprop` output=1.
- **Source stalls**: `src_valid` toggling 1,0,1,0 with wlast=1.
  - `waddr` advances only on valid cycles; exactly 2 `wwrite` pulses.
- **Skip load and drain hold**: `cmd_skip_load`=1.
  - `s_init` at cycle 1; `s_fin` while `out_busy`=1 for 5 cycles; `done` only after `out_busy` falls.
- **Abort**: `abort` in WLOAD after 2 words and again in RUN.
  - IDLE next cycle, no `done`, `cmd_ready`=1.
  - The next command restarts at `waddr`=0.
- **Reset and spurious inputs**
  - Async `rst` mid-BLOAD clears all outputs immediately.
  - Spurious `s_fin` and `cmd_valid` during load cause no state change.

Source files
------------

// File: rtl/tiny_dnn_pkg.sv
// Shared types and width defaults for the layer sequencer.
package tiny_dnn_pkg;

    localparam int WA_W_DEF = 10;
    localparam int BA_W_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_BLOAD,
        S_INIT,
        S_RUN,
        S_DRAIN,
        S_DONE
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tiny_dnn_ld_cnt.sv
// Load counter shared by the weight and bias load phases.
module tiny_dnn_ld_cnt #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic [CW-1:0] last_val,
    output logic [CW-1:0] cnt,
    output logic          cnt_last
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over increment so the last accepted word leaves the counter at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign cnt_last = (cnt_q == last_val);

endmodule

// File: rtl/tiny_dnn_layer_seq.sv
// Layer sequencer: loads weights/biases, starts the execution controller,
// waits for it to finish and for the output path to drain.
//
// state   | meaning
// IDLE    | waiting for a layer command
// WLOAD   | streaming weight words into the weight buffer
// BLOAD   | streaming bias words into the bias buffer
// INIT    | one-cycle start pulse to the execution controller
// RUN     | execution controller busy, waiting for s_fin
// DRAIN   | waiting for the output path to empty
// DONE    | one-cycle completion pulse
module tiny_dnn_layer_seq
    import tiny_dnn_pkg::*;
#(
    parameter int WA_W = WA_W_DEF,
    parameter int BA_W = BA_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_backprop,
    input  logic            cmd_skip_load,
    input  logic [WA_W-1:0] cmd_wlast,
    input  logic [BA_W-1:0] cmd_blast,
    input  logic            abort,
    input  logic            src_valid,
    output logic            src_ready,
    output logic            wwrite,
    output logic            bwrite,
    output logic [WA_W-1:0] waddr,
    output logic [BA_W-1:0] baddr,
    output logic            backprop,
    output logic            run,
    output logic            s_init,
    input  logic            s_fin,
    input  logic            out_busy,
    output logic            busy,
    output logic            done
);

    localparam int CW = max_int(WA_W, BA_W);

    seq_state_t      state_q, state_d;
    logic            backprop_q, backprop_d;
    logic [WA_W-1:0] wlast_q, wlast_d;
    logic [BA_W-1:0] blast_q, blast_d;

    logic            loading;
    logic            accept;
    logic            cnt_clr;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   last_val;
    logic            cnt_last;

    assign loading  = (state_q == S_WLOAD) || (state_q == S_BLOAD);
    assign accept   = loading && src_valid && !abort;
    assign last_val = (state_q == S_BLOAD) ? CW'(blast_q) : CW'(wlast_q);

    tiny_dnn_ld_cnt #(.CW(CW)) u_ld_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .inc      (accept),
        .last_val (last_val),
        .cnt      (cnt),
        .cnt_last (cnt_last)
    );

    always_comb begin
        state_d    = state_q;
        backprop_d = backprop_q;
        wlast_d    = wlast_q;
        blast_d    = blast_q;
        cnt_clr    = 1'b0;
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        backprop_d = cmd_backprop;
                        wlast_d    = cmd_wlast;
                        blast_d    = cmd_blast;
                        cnt_clr    = 1'b1;
                        state_d    = cmd_skip_load ? S_INIT : S_WLOAD;
                    end
                end
                S_WLOAD: begin
                    if (accept && cnt_last) begin
                        cnt_clr = 1'b1;
                        // Backprop layers carry no bias.
                        state_d = backprop_q ? S_INIT : S_BLOAD;
                    end
                end
                S_BLOAD: begin
                    if (accept && cnt_last) begin
                        cnt_clr = 1'b1;
                        state_d = S_INIT;
                    end
                end
                S_INIT:  state_d = S_RUN;
                S_RUN:   if (s_fin) state_d = S_DRAIN;
                S_DRAIN: if (!out_busy) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            backprop_q <= 1'b0;
            wlast_q    <= '0;
            blast_q    <= '0;
        end else begin
            state_q    <= state_d;
            backprop_q <= backprop_d;
            wlast_q    <= wlast_d;
            blast_q    <= blast_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign src_ready = loading && !abort;
    assign wwrite    = (state_q == S_WLOAD) && src_valid && !abort;
    assign bwrite    = (state_q == S_BLOAD) && src_valid && !abort;
    assign waddr     = cnt[WA_W-1:0];
    assign baddr     = cnt[BA_W-1:0];
    assign backprop  = backprop_q;
    assign run       = (state_q == S_INIT) || (state_q == S_RUN);
    // Start and completion pulses are suppressed on abort so nothing downstream sees a stray event.
    assign s_init    = (state_q == S_INIT) && !abort;
    assign done      = (state_q == S_DONE) && !abort;

endmodule

// File: tb/tb_tiny_dnn_layer_seq.sv
// Randomized self-checking bench for tiny_dnn_layer_seq against a write-list reference model.
module tb_tiny_dnn_layer_seq;

    localparam int WA_W = 10;
    localparam int BA_W = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid, cmd_ready, cmd_backprop, cmd_skip_load;
    logic [WA_W-1:0] cmd_wlast;
    logic [BA_W-1:0] cmd_blast;
    logic            abort, src_valid, src_ready, wwrite, bwrite;
    logic [WA_W-1:0] waddr;
    logic [BA_W-1:0] baddr;
    logic            backprop, run, s_init, s_fin, out_busy, busy, done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit is_b;
        int addr;
    } wr_t;

    tiny_dnn_layer_seq #(.WA_W(WA_W), .BA_W(BA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_backprop  (cmd_backprop),
        .cmd_skip_load (cmd_skip_load),
        .cmd_wlast     (cmd_wlast),
        .cmd_blast     (cmd_blast),
        .abort         (abort),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .wwrite        (wwrite),
        .bwrite        (bwrite),
        .waddr         (waddr),
        .baddr         (baddr),
        .backprop      (backprop),
        .run           (run),
        .s_init        (s_init),
        .s_fin         (s_fin),
        .out_busy      (out_busy),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        cmd_valid = 0; cmd_backprop = 0; cmd_skip_load = 0;
        cmd_wlast = '0; cmd_blast = '0; abort = 0;
        src_valid = 0; s_fin = 0; out_busy = 0;
    endtask

    // Full command: expected writes are the plain list w0..wlast then b0..blast (forward only).
    task automatic do_cmd(input bit bp, input bit skip, input int wl, input int bl,
                          input int stall_mode, input bit spur, input int fin_delay,
                          input int busy_cyc, input string tag);
        wr_t q[$];
        int  c;
        @(negedge clk);
        cmd_valid = 1; cmd_backprop = bp; cmd_skip_load = skip;
        cmd_wlast = WA_W'(wl); cmd_blast = BA_W'(bl);
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s cmd_accept: cmd_ready=%b busy=%b expected 1/0", tag, cmd_ready, busy);
        end
        if (!skip) begin
            for (int i = 0; i <= wl; i++) q.push_back('{1'b0, i});
            if (!bp) for (int i = 0; i <= bl; i++) q.push_back('{1'b1, i});
        end
        c = 0;
        while (q.size() > 0 && c < 400) begin
            @(negedge clk);
            cmd_valid = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_skip_load = 1'($urandom_range(0, 1));
            s_fin = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            case (stall_mode)
                0:       src_valid = 1'b1;
                1:       src_valid = (c % 2 == 0);
                default: src_valid = ($urandom_range(0, 3) != 0);
            endcase
            #1;
            checks++;
            if ({wwrite, bwrite, src_ready, s_init, cmd_ready} !==
                {src_valid & !q[0].is_b, src_valid & q[0].is_b, 1'b1, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL %s load_strobes: ww/bw/rdy/init/cr=%b%b%b%b%b expected %b%b100",
                         tag, wwrite, bwrite, src_ready, s_init, cmd_ready,
                         src_valid & !q[0].is_b, src_valid & q[0].is_b);
            end
            if (src_valid) begin
                checks++;
                if (q[0].is_b ? (int'(baddr) != q[0].addr) : (int'(waddr) != q[0].addr)) begin
                    failures++;
                    $display("FAIL %s load_addr: waddr=%0d baddr=%0d expected %s addr %0d",
                             tag, waddr, baddr, q[0].is_b ? "bias" : "weight", q[0].addr);
                end
                void'(q.pop_front());
            end
            c++;
        end
        if (q.size() > 0) begin
            checks++; failures++;
            $display("FAIL %s load_timeout: %0d writes outstanding, expected 0", tag, q.size());
        end
        @(negedge clk);
        idle_inputs();
        src_valid = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if ({s_init, run, backprop, wwrite, bwrite, src_ready} !== {1'b1, 1'b1, bp, 3'b000}) begin
            failures++;
            $display("FAIL %s start: init/run/bp/ww/bw/rdy=%b%b%b%b%b%b expected 11%b000",
                     tag, s_init, run, backprop, wwrite, bwrite, src_ready, bp);
        end
        src_valid = 0;
        for (int i = 0; i < fin_delay; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({run, s_init, done} !== 3'b100) begin
                failures++;
                $display("FAIL %s run_wait: run/init/done=%b%b%b expected 100", tag, run, s_init, done);
            end
        end
        @(negedge clk); s_fin = 1; #1;
        checks++;
        if (run !== 1'b1) begin
            failures++;
            $display("FAIL %s fin_cycle: run=%b expected 1", tag, run);
        end
        for (int i = 0; i < busy_cyc; i++) begin
            @(negedge clk); s_fin = 0; out_busy = 1; #1;
            checks++;
            if ({run, done, busy} !== 3'b001) begin
                failures++;
                $display("FAIL %s drain_hold: run/done/busy=%b%b%b expected 001", tag, run, done, busy);
            end
        end
        @(negedge clk); s_fin = 0; out_busy = 0; #1;
        checks++;
        if ({run, done, busy} !== 3'b001) begin
            failures++;
            $display("FAIL %s drain_exit: run/done/busy=%b%b%b expected 001", tag, run, done, busy);
        end
        @(negedge clk); #1;
        checks++;
        if ({done, busy, cmd_ready} !== 3'b110) begin
            failures++;
            $display("FAIL %s done_pulse: done/busy/cr=%b%b%b expected 110", tag, done, busy, cmd_ready);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if ({cmd_ready, src_ready, wwrite, bwrite, backprop, run, s_init, busy, done} !== 9'b100000000
            || waddr !== '0 || baddr !== '0) begin
            failures++;
            $display("FAIL reset_values: cr/rdy/ww/bw/bp/run/init/busy/done=%b%b%b%b%b%b%b%b%b waddr=%0d baddr=%0d expected 100000000 0 0",
                     cmd_ready, src_ready, wwrite, bwrite, backprop, run, s_init, busy, done, waddr, baddr);
        end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_forward();
        do_cmd(0, 0, 3, 1, 0, 0, 2, 0, "forward");
    endtask

    task automatic test_backprop();
        do_cmd(1, 0, 2, 5, 0, 0, 1, 0, "backprop");
    endtask

    task automatic test_stalls();
        do_cmd(0, 0, 1, 0, 1, 0, 0, 0, "stalls");
    endtask

    task automatic test_skip_drain();
        do_cmd(0, 1, 7, 7, 0, 0, 3, 5, "skip_drain");
    endtask

    task automatic test_boundaries();
        do_cmd(0, 0, 0, 0, 2, 0, 0, 0, "min_load");
        do_cmd(0, 0, 2, 15, 2, 0, 0, 1, "max_blast");
    endtask

    task automatic test_abort();
        @(negedge clk);
        cmd_valid = 1; cmd_backprop = 0; cmd_skip_load = 0; cmd_wlast = 10'd5; cmd_blast = 4'd2;
        @(negedge clk); cmd_valid = 0; src_valid = 1;
        @(negedge clk);
        @(negedge clk); abort = 1; #1;
        checks++;
        if ({wwrite, src_ready} !== 2'b00) begin
            failures++;
            $display("FAIL abort_strobe: wwrite/src_ready=%b%b expected 00", wwrite, src_ready);
        end
        @(negedge clk); abort = 0; #1;
        checks++;
        if ({cmd_ready, busy, wwrite, done} !== 4'b1000) begin
            failures++;
            $display("FAIL abort_load_idle: cr/busy/ww/done=%b%b%b%b expected 1000", cmd_ready, busy, wwrite, done);
        end
        src_valid = 0;
        do_cmd(0, 0, 2, 1, 0, 0, 0, 0, "after_abort");
        @(negedge clk);
        cmd_valid = 1; cmd_skip_load = 1;
        @(negedge clk); idle_inputs();
        @(negedge clk); abort = 1; #1;
        checks++;
        if (run !== 1'b1) begin
            failures++;
            $display("FAIL abort_run_state: run=%b expected 1", run);
        end
        @(negedge clk); abort = 0; s_fin = 1; #1;
        checks++;
        if ({cmd_ready, busy, run, done} !== 4'b1000) begin
            failures++;
            $display("FAIL abort_run_idle: cr/busy/run/done=%b%b%b%b expected 1000", cmd_ready, busy, run, done);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); s_fin = 0; abort = 1; #1;
            checks++;
            if ({cmd_ready, done} !== 2'b10) begin
                failures++;
                $display("FAIL abort_no_done: cr/done=%b%b expected 10", cmd_ready, done);
            end
        end
        abort = 0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        cmd_valid = 1; cmd_backprop = 0; cmd_skip_load = 0; cmd_wlast = 10'd1; cmd_blast = 4'd3;
        @(negedge clk); cmd_valid = 0; src_valid = 1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if ({bwrite, baddr} !== {1'b1, 4'd1}) begin
            failures++;
            $display("FAIL pre_reset_bload: bwrite=%b baddr=%0d expected 1 1", bwrite, baddr);
        end
        rst = 1; #1;
        checks++;
        if ({bwrite, wwrite, src_ready, busy, cmd_ready, run} !== 6'b000010 || baddr !== '0 || waddr !== '0) begin
            failures++;
            $display("FAIL async_reset: bw/ww/rdy/busy/cr/run=%b%b%b%b%b%b baddr=%0d waddr=%0d expected 000010 0 0",
                     bwrite, wwrite, src_ready, busy, cmd_ready, run, baddr, waddr);
        end
        @(negedge clk); rst = 0; src_valid = 0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            do_cmd(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, 12)), int'($urandom_range(0, 15)),
                   2, 1, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_backprop();
        test_stalls();
        test_skip_drain();
        test_boundaries();
        test_abort();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
